// File: rtl/div_tick_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : div_tick_gen_if
// Purpose  : Bundles the divider bus, tick selection/control inputs and the
//            tick/strobe outputs of div_tick_gen.
// Ports    : clkdiv[31:0], sel[4:0], en, period[CNT_W-1:0]  (master -> slave)
//            tick, strobe, tick_count[CNT_W-1:0]           (slave -> master)
// Revision : 1.0  initial release
// ============================================================================
interface div_tick_gen_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      clkdiv;
    logic [4:0]       sel;
    logic             en;
    logic [CNT_W-1:0] period;
    logic             tick;
    logic             strobe;
    logic [CNT_W-1:0] tick_count;

    modport master (
        output clkdiv, sel, en, period,
        input  tick, strobe, tick_count
    );

    modport slave (
        input  clkdiv, sel, en, period,
        output tick, strobe, tick_count
    );
endinterface
`default_nettype wire

// File: rtl/div_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : div_tick_gen
// Purpose  : Turns rising edges of a runtime-selected clkdiv bit into
//            single-cycle clk-domain enables (tick), and divides those ticks
//            by a programmable period into a strobe pulse.
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            bus.slave  - clkdiv/sel/en/period in, tick/strobe/tick_count out
// Revision : 1.0  initial release
// ============================================================================
module div_tick_gen #(
    parameter int CNT_W = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    div_tick_gen_if.slave bus
);

    logic             bit_q;
    logic [4:0]       sel_q;
    logic             armed;
    logic             tick_q;
    logic             strobe_q;
    logic [CNT_W-1:0] count_q;

    logic             bit_now;
    logic             edge_ok;
    logic [CNT_W:0]   period_eff;
    logic [CNT_W:0]   count_inc;

    always_comb begin
        bit_now = bus.clkdiv[bus.sel];
        // A select change invalidates bit_q (it belongs to another bit), and
        // the first cycle after reset has no valid history yet.
        edge_ok = bit_now & ~bit_q & (bus.sel == sel_q) & armed & bus.en;
        // One extra bit keeps count+1 from wrapping at the top of the range.
        count_inc  = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
        period_eff = (bus.period <= CNT_W'(1)) ? {{CNT_W{1'b0}}, 1'b1}
                                               : {1'b0, bus.period};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q    <= 1'b0;
            sel_q    <= 5'd0;
            armed    <= 1'b0;
            tick_q   <= 1'b0;
            strobe_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // Edge history tracks the bus even while disabled, so an edge
            // seen during en=0 is consumed rather than deferred.
            bit_q  <= bit_now;
            sel_q  <= bus.sel;
            armed  <= 1'b1;
            tick_q <= edge_ok;
            if (edge_ok) begin
                // ">=" lets a shrunken period strobe on the very next tick.
                if (count_inc >= period_eff) begin
                    strobe_q <= 1'b1;
                    count_q  <= '0;
                end else begin
                    strobe_q <= 1'b0;
                    count_q  <= count_inc[CNT_W-1:0];
                end
            end else begin
                strobe_q <= 1'b0;
            end
        end
    end

    assign bus.tick       = tick_q;
    assign bus.strobe     = strobe_q;
    assign bus.tick_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_div_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_tick_gen
// Purpose  : Self-checking bench for div_tick_gen. A behavioural model pushes
//            the expected outputs for every driven cycle into a scoreboard
//            queue; they are popped and compared after the clock edge.
//            Directed checks cover the scenarios of each test phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_tick_gen;

    localparam int CNT_W = 16;

    typedef struct {
        logic tick;
        logic strobe;
        int   cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exp_t sb[$];

    // model state
    logic       m_bit;
    logic [4:0] m_sel;
    logic       m_armed;
    int         m_cnt;
    logic       prev_tick;

    div_tick_gen_if #(.CNT_W(CNT_W)) bus ();

    div_tick_gen #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: model predicts, DUT steps, scoreboard compares, divider advances.
    task automatic cycle();
        exp_t e;
        logic b;
        logic hit;
        int   pe;
        b = bus.clkdiv[bus.sel];
        if (rst) begin
            e = '{1'b0, 1'b0, 0};
            m_bit = 1'b0; m_sel = 5'd0; m_armed = 1'b0; m_cnt = 0;
        end else begin
            hit = b && !m_bit && (bus.sel == m_sel) && m_armed && bus.en;
            pe  = (bus.period <= 1) ? 1 : int'(bus.period);
            e.tick   = hit;
            e.strobe = 1'b0;
            if (hit) begin
                if (m_cnt + 1 >= pe) begin
                    e.strobe = 1'b1;
                    m_cnt    = 0;
                end else begin
                    m_cnt++;
                end
            end
            e.cnt   = m_cnt;
            m_bit   = b;
            m_sel   = bus.sel;
            m_armed = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("sb_tick",   32'(bus.tick),       32'(e.tick));
        check_val("sb_strobe", 32'(bus.strobe),     32'(e.strobe));
        check_val("sb_count",  32'(bus.tick_count), 32'(e.cnt));
        check_val("pulse_width", 32'(prev_tick & bus.tick), 32'd0);
        prev_tick  = bus.tick;
        bus.clkdiv = bus.clkdiv + 32'd1;
    endtask

    task automatic wait_tick(input string tag);
        int g;
        g = 0;
        do begin
            cycle();
            g++;
        end while (!bus.tick && g < 64);
        check_val(tag, 32'(bus.tick), 32'd1);
    endtask

    task automatic wait_count(input string tag, input int target);
        int g;
        g = 0;
        while (int'(bus.tick_count) != target && g < 300) begin
            cycle();
            g++;
        end
        check_val(tag, 32'(bus.tick_count), 32'(target));
    endtask

    initial begin
        int nt, ns, k, last, g;
        n_checks = 0; n_fail = 0;
        m_bit = 1'b0; m_sel = 5'd0; m_armed = 1'b0; m_cnt = 0;
        prev_tick = 1'b0;

        // ---- 1: reset, fastest bit, period 1
        rst = 1'b1; bus.clkdiv = 32'd0; bus.sel = 5'd0; bus.en = 1'b1;
        bus.period = 16'd1;
        cycle();
        check_val("rst_tick",   32'(bus.tick),       32'd0);
        check_val("rst_strobe", 32'(bus.strobe),     32'd0);
        check_val("rst_count",  32'(bus.tick_count), 32'd0);
        rst = 1'b0;
        bus.clkdiv = 32'd0;
        nt = 0; ns = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            nt += int'(bus.tick);
            ns += int'(bus.strobe);
        end
        check_val("t1_ticks",   32'(nt), 32'd10);
        check_val("t1_strobes", 32'(ns), 32'd10);

        // ---- 2: sel 3, period 4
        bus.sel = 5'd3; bus.period = 16'd4;
        k = 0; ns = 0; last = -1;
        for (int i = 0; i < 128; i++) begin
            cycle();
            ns += int'(bus.strobe);
            if (bus.tick) begin
                k++;
                check_val("t2_count_step", 32'(bus.tick_count), 32'(k % 4));
                if (last >= 0) check_val("t2_interval", 32'(i - last), 32'd16);
                last = i;
            end
        end
        check_val("t2_ticks",   32'(k),  32'd8);
        check_val("t2_strobes", 32'(ns), 32'd2);

        // ---- 3: select change on a clkdiv[1] rise while clkdiv[3] is low
        g = 0;
        while ((bus.clkdiv % 16) != 2 && g < 32) begin
            cycle();
            g++;
        end
        bus.sel = 5'd1;
        cycle();
        check_val("t3_switch_no_tick", 32'(bus.tick), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("t3_next_edge", 32'(bus.tick), 32'(i == 3));
        end

        // ---- 4: enable gating, sel 2
        bus.sel = 5'd2; bus.period = 16'd8;
        wait_count("t4_reach_2", 2);
        bus.en = 1'b0;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            nt += int'(bus.tick);
        end
        check_val("t4_no_ticks", 32'(nt), 32'd0);
        check_val("t4_frozen",   32'(bus.tick_count), 32'd2);
        bus.en = 1'b1;
        wait_tick("t4_resume_tick");
        check_val("t4_resume_count", 32'(bus.tick_count), 32'd3);

        // ---- 5: period shrink 8 -> 2 with count at 5
        wait_count("t5_reach_5", 5);
        bus.period = 16'd2;
        wait_tick("t5_shrink_tick");
        check_val("t5_shrink_strobe", 32'(bus.strobe),     32'd1);
        check_val("t5_shrink_count",  32'(bus.tick_count), 32'd0);
        for (int j = 0; j < 4; j++) begin
            wait_tick("t5_tick");
            check_val("t5_strobe_every2", 32'(bus.strobe), 32'(j % 2 == 1));
        end

        // ---- 6: reset mid-run, divider keeps running
        bus.period = 16'd8;
        wait_count("t6_reach_3", 3);
        g = 0;
        while ((bus.clkdiv % 8) != 3 && g < 16) begin
            cycle();
            g++;
        end
        check_val("t6_pre_count", 32'(bus.tick_count), 32'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("t6_rst_tick",   32'(bus.tick),       32'd0);
        check_val("t6_rst_strobe", 32'(bus.strobe),     32'd0);
        check_val("t6_rst_count",  32'(bus.tick_count), 32'd0);
        cycle();
        check_val("t6_first_cycle_no_tick", 32'(bus.tick), 32'd0);
        nt = 0;
        do begin
            cycle();
            nt++;
        end while (!bus.tick && nt < 20);
        check_val("t6_cycles_to_tick", 32'(nt), 32'd8);
        check_val("t6_count_after",    32'(bus.tick_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_tick_gen.md
# div_tick_gen

Consumer of the free-running `clkdiv` bus from the clock divider. Detects rising edges on a runtime-selected divider bit and converts them into single-cycle enable pulses (`tick`) in the `clk` domain. It also counts those ticks into a programmable-period `strobe` for game-rate events such as tank movement and shell steps. Game logic runs entirely on `clk` and uses these enables instead of clocking from divider bits.

## Interface

Parameters:
- `CNT_W`, 16, width of `period` and `tick_count`.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  reset, synchronous and active-high.
- `clkdiv`  input  32  free-running divider bus, synchronous to `clk`.
- `sel`  input  5  index of the `clkdiv` bit to monitor.
- `en`  input  1  tick enable; when low, no ticks and the count holds.
- `period`  input  CNT_W  ticks per strobe; values 0 and 1 both mean every tick.
- `tick`  output  1  one-cycle pulse per qualified rising edge of `clkdiv[sel]`.
- `strobe`  output  1  one-cycle pulse on every `period`-th tick, coincident with that tick.
- `tick_count`  output  CNT_W  ticks since the last strobe.

## Operation

- Registers:
  - `bit_q`: last sampled `clkdiv[sel]`.
  - `sel_q`: last `sel`.
  - `armed`: 0 after reset, set to 1 after the first sample.
  - `tick`, `strobe`, `tick_count`.
- Every cycle: `bit_q` <= `clkdiv[sel]` and `sel_q` <= `sel`. This happens regardless of `en`.
- Edge qualified when all of the following hold:
  - `clkdiv[sel]` = 1 and `bit_q` = 0;
  - `sel` == `sel_q`;
  - `armed` = 1;
  - `en` = 1.
- Consequences of the qualification rule:
  - A `sel` change suppresses edge detection for exactly one cycle, so there is no spurious tick from the bit switch.
  - The first cycle after reset only samples and never ticks.
- `period_eff` = 1 if `period` ≤ 1, else `period`. `period` is sampled combinationally at each tick and is not latched.
- On a qualified edge:
  - `tick` <= 1.
  - If `tick_count` + 1 ≥ `period_eff`: `strobe` <= 1 and `tick_count` <= 0.
  - Else: `strobe` <= 0 and `tick_count` <= `tick_count` + 1.
- When no edge qualifies: `tick` <= 0, `strobe` <= 0, `tick_count` holds.
- Compare width: the compare uses CNT_W+1 bits, so `tick_count` never wraps.
- Period shrink: if `period` is lowered below the current count, the next tick strobes and clears the count.
- `en` low: edges are ignored, but `bit_q` keeps tracking. A rising edge that occurs while `en` is low is lost; it is not deferred to when `en` returns high.

## Timing

- Reset (`rst` high at a `clk` edge): `tick` = 0, `strobe` = 0, `tick_count` = 0, `bit_q` = 0, `sel_q` = 0, `armed` = 0 after that edge.
- Reset mid-operation: outputs clear on the next edge, and any pending tick is dropped.
- Latency: if cycle t is the first cycle in which `clkdiv[sel]` is sampled high, `tick` is high during cycle t+1 (one register stage). `strobe` and the updated `tick_count` appear in the same cycle as `tick`.
- Tick rate: with a normally counting divider, bit k rises every 2^(k+1) `clk` cycles.
  - `sel` = 0 gives a tick every 2 cycles.
  - `sel` ≥ 1 gives ticks 2^(k+1) cycles apart.
- Pulse width: `tick` and `strobe` are never high for two consecutive cycles.
- Bit 31 is legal; its edges occur every 2^32 cycles.

## Test plan

1. **Fastest bit.** Reset with the divider counting from 0; `sel` = 0, `en` = 1, `period` = 1. Expect `tick` and `strobe` high together every 2nd cycle, and `tick_count` always 0.
2. **Period count.** `sel` = 3, `period` = 4. Expect ticks every 16 cycles, with `tick_count` stepping 1, 2, 3, 0. `strobe` fires only on the 4th tick, i.e. every 64 cycles.
3. **Select change.** Switch `sel` 3 → 1 in the cycle where `clkdiv[1]` rises while `clkdiv[3]` = 0. Expect no `tick` for that edge; the next `clkdiv[1]` rise, 4 cycles later, ticks.
4. **Enable gating.** Drop `en` for 40 cycles with `sel` = 2. Expect zero ticks and `tick_count` frozen at its value, e.g. 2. After re-enable, the first tick arrives on the next rising edge of bit 2 and the count resumes from 2.
5. **Period shrink.** `period` = 8 with `tick_count` = 5; change `period` to 2. Expect the next tick to assert `strobe` and `tick_count` to go to 0. Afterwards, strobes occur every 2 ticks.
6. **Reset mid-run.** Assert `rst` for 1 cycle while `tick_count` = 3, with the divider not reset and `clkdiv[sel]` high on release. Expect `tick` = `strobe` = 0 and `tick_count` = 0. Expect no tick in the first post-reset cycle; the first tick comes on the following genuine rising edge.
